// File: rtl/uart_tx_mmio_if.sv
// Data-side bus between the processor and a memory-mapped slave, shaped like
// the dmem slave port so the SoC can steer accesses between slaves by address.
interface uart_tx_mmio_if;
   logic [31:0] ip_data_addr;
   logic        ip_data_wr;
   logic [3:0]  ip_data_mask;
   logic [31:0] ip_data_from_proc;
   logic        ip_data_rd;
   logic        op_data_valid;
   logic [31:0] op_data_to_proc;

   modport master (
      output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
      input  op_data_valid, op_data_to_proc
   );

   modport slave (
      input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
      output op_data_valid, op_data_to_proc
   );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA writes feed a small FIFO that a
// start/data/stop FSM drains onto op_tx; STATUS exposes count and flags.
module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_mmio_if.slave bus,
   output logic          op_tx
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;

   logic        sel, wr_txdata, wr_status;
   logic        fifo_empty, fifo_full, push, pop, baud_done;
   logic [31:0] status;
   logic        unused_bits;

   assign sel        = (bus.ip_data_addr[31:3] == BASE_ADDR[31:3]);
   assign wr_txdata  = bus.ip_data_wr & sel & ~bus.ip_data_addr[2] & bus.ip_data_mask[0];
   assign wr_status  = bus.ip_data_wr & sel &  bus.ip_data_addr[2] & bus.ip_data_mask[0];
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FULL_CNT);
   assign baud_done  = (baud_q == BAUD_LAST);
   assign unused_bits = ^{bus.ip_data_addr[1:0], bus.ip_data_mask[3:1], bus.ip_data_from_proc[31:8]};

   // Fullness is judged before the edge, so a same-edge pop never rescues a push.
   always_comb begin
      push   = wr_txdata & ~fifo_full;
      wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      ovf_d = ovf_q;
      if (wr_status && bus.ip_data_from_proc[3]) ovf_d = 1'b0;
      if (wr_txdata && fifo_full)                ovf_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_START;
         S_START: if (baud_done) state_d = S_DATA;
         S_DATA:  if (baud_done && bit_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (baud_done) state_d = fifo_empty ? S_IDLE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   // tx is computed from next state so the registered line changes with the state.
   always_comb begin
      pop     = 1'b0;
      shift_d = shift_q;
      bit_d   = bit_q;
      if (!fifo_empty && (state_q == S_IDLE || (state_q == S_STOP && baud_done))) begin
         pop     = 1'b1;
         shift_d = mem_q[rptr_q];
         bit_d   = 3'd0;
      end else if (state_q == S_DATA && baud_done) begin
         shift_d = {1'b0, shift_q[7:1]};
         bit_d   = bit_q + 3'd1;
      end
      if (state_d != state_q || baud_done || state_q == S_IDLE) baud_d = '0;
      else                                                      baud_d = baud_q + BAUD_W'(1);
      unique case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.ip_data_from_proc[7:0];
   end

   assign status = {24'b0, 4'(cnt_q), ovf_q, fifo_empty, fifo_full, state_q != S_IDLE};

   assign bus.op_data_valid   = bus.ip_data_rd & sel;
   assign bus.op_data_to_proc = (bus.op_data_valid && bus.ip_data_addr[2]) ? status : 32'b0;
   assign op_tx               = tx_q;
endmodule
